// File: rtl/ibr128_block_arbiter.sv
// Purpose : round-robin arbiter/sequencer sharing one IBR128_encrypt engine between NREQ block requesters.
// Latency : accept at T, eng_block_start at T+1, resp_valid one cycle after block_ready is seen in BUSY.
// Backpr. : one block in flight; req_ready only in IDLE; RESP holds until resp_ready of the granted requester.
//
// Ports:
//   Clk, RstN                       clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready             per-requester request handshake (req_ready is a one-hot accept pulse)
//   req_encrypt/req_sa              per-requester engine mode flags
//   req_data/req_key                per-requester 128-bit block and {key1,key0}, requester i at [i*128 +: 128]
//   resp_valid/resp_ready           per-requester result handshake (resp_valid one-hot)
//   resp_data/resp_err              shared result block; resp_err marks an engine timeout
//   eng_*                           engine side: block_start pulse, pData/keys/flags, block_ready/eData return
//
// Optional feature: define IBR128_ARB_TIMEOUT_EN to enable a BUSY watchdog of TIMEOUT_CYC cycles.
module ibr128_block_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                Clk,
  input  logic                RstN,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_encrypt,
  input  logic [NREQ-1:0]     req_sa,
  input  logic [NREQ*128-1:0] req_data,
  input  logic [NREQ*128-1:0] req_key,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [127:0]        resp_data,
  output logic                resp_err,
  output logic                eng_encrypt,
  output logic                eng_sa,
  output logic                eng_block_start,
  output logic [127:0]        eng_pData,
  output logic [63:0]         eng_key0,
  output logic [63:0]         eng_key1,
  input  logic                eng_block_ready,
  input  logic [127:0]        eng_eData
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   pick;
  logic            any_vld;
  logic [127:0]    hold_data;
  logic [127:0]    hold_key;
  logic            hold_enc;
  logic            hold_sa;
  logic            resp_hs;
  logic            timed_out;

  function automatic int wrap_idx(input int a);
    return (a >= NREQ) ? a - NREQ : a;
  endfunction

  // Scan from the farthest candidate back to rr_ptr so the closest set bit
  // at or after rr_ptr is the last one written and therefore wins.
  always_comb begin
    pick    = '0;
    any_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
        pick    = IW'(wrap_idx(int'(rr_ptr) + k));
        any_vld = 1'b1;
      end
    end
  end

  assign resp_hs = (state == S_RESP) && resp_ready[gnt];

`ifdef IBR128_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt;

  // Counter holds the number of completed BUSY cycles; the last allowed
  // cycle is the one where it equals TIMEOUT_CYC-1.
  assign timed_out = (state == S_BUSY) && !eng_block_ready &&
                     (to_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      to_cnt <= '0;
    end else if (state == S_START) begin
      to_cnt <= '0;
    end else if (state == S_BUSY) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_vld) state_nxt = S_START;
      S_START: state_nxt = S_BUSY;
      S_BUSY:  if (eng_block_ready || timed_out) state_nxt = S_RESP;
      S_RESP:  if (resp_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      hold_data <= '0;
      hold_key  <= '0;
      hold_enc  <= 1'b0;
      hold_sa   <= 1'b0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_vld) begin
        gnt       <= pick;
        hold_data <= req_data[int'(pick)*128 +: 128];
        hold_key  <= req_key[int'(pick)*128 +: 128];
        hold_enc  <= req_encrypt[pick];
        hold_sa   <= req_sa[pick];
      end
      if (state == S_BUSY && eng_block_ready) begin
        resp_data <= eng_eData;
      end else if (timed_out) begin
        resp_data <= '0;
      end
      if (resp_hs) begin
        rr_ptr <= IW'(wrap_idx(int'(gnt) + 1));
      end
    end
  end

`ifdef IBR128_ARB_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      err_q <= 1'b0;
    end else if (state == S_BUSY && eng_block_ready) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  // req_ready is combinational from IDLE; gating with RstN keeps every
  // output at zero while reset is held even if requesters stay valid.
  assign req_ready       = (state == S_IDLE && any_vld && RstN) ?
                           ({{(NREQ-1){1'b0}}, 1'b1} << pick) : '0;
  assign resp_valid      = (state == S_RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt) : '0;
  assign eng_block_start = (state == S_START);
  assign eng_pData       = hold_data;
  assign eng_key0        = hold_key[63:0];
  assign eng_key1        = hold_key[127:64];
  assign eng_encrypt     = hold_enc;
  assign eng_sa          = hold_sa;

endmodule
